// File: rtl/uart_pkg.sv
// Shared UART MMIO definitions: register map, CON bit indices, FSM encodings.
// Used by uart_mmio and uart_rx_core.
package uart_pkg;

  localparam logic [31:0] ADDR_TXD = 32'h4000_0018;
  localparam logic [31:0] ADDR_RXD = 32'h4000_001C;
  localparam logic [31:0] ADDR_CON = 32'h4000_0020;

  localparam int CON_TX_BUSY = 0;
  localparam int CON_TX_DONE = 1;
  localparam int CON_RX_VLD  = 2;
  localparam int CON_RX_OVR  = 3;
  localparam int CON_IRQ_EN  = 4;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  function automatic logic reg_sel(
    input logic [31:0] a,
    input logic [31:0] r
  );
    return a[31:2] == r[31:2];
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchronizer, start-bit qualify, 8N1 deserializer.
// done_o pulses for one cycle when a frame ends with a valid stop bit.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 10417
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       done_o
);

  localparam logic [15:0] LAST = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF = 16'(BAUD_DIV / 2 - 1);

  logic [1:0]  sync_q;
  logic        prev_q;
  logic        rx_s;
  rx_state_t   st_q, st_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;

  assign rx_s   = sync_q[1];
  assign byte_o = sh_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
      st_q   <= RX_IDLE;
      cnt_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
    end else begin
      sync_q <= {sync_q[0], rx_i};
      prev_q <= rx_s;
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    bit_d  = bit_q;
    sh_d   = sh_q;
    done_o = 1'b0;
    unique case (st_q)
      RX_IDLE: begin
        if (prev_q && !rx_s) begin
          st_d  = RX_START;
          cnt_d = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF) begin
          cnt_d = '0;
          bit_d = '0;
          st_d  = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RX_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          sh_d  = {rx_s, sh_q[7:1]};
          if (bit_q == 3'd7) st_d = RX_STOP;
          else bit_d = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RX_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d  = '0;
          st_d   = RX_IDLE;
          done_o = rx_s;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: st_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART (TXD/RXD/CON) with level irq.
// Receiver compiled only when UART_MMIO_RX_EN is defined.
module uart_mmio
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 10417
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] Read_data,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        irq
);

  localparam logic [15:0] LAST = 16'(BAUD_DIV - 1);

  logic sel_txd, sel_rxd, sel_con;
  logic txd_wr, con_wr, rxd_rd;

  assign sel_txd = reg_sel(Address, ADDR_TXD);
  assign sel_rxd = reg_sel(Address, ADDR_RXD);
  assign sel_con = reg_sel(Address, ADDR_CON);
  assign txd_wr  = MemWrite & sel_txd;
  assign con_wr  = MemWrite & sel_con;
  assign rxd_rd  = MemRead & sel_rxd;

  tx_state_t   tx_st_q, tx_st_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        tx_q, tx_d;
  logic        done_set, cnt_end, tx_busy;
  logic        tx_done_q, tx_done_d;
  logic        irq_en_q, irq_en_d;
  logic        irq_q;

  logic        rx_valid_q, rx_ovr_q;
  logic [7:0]  rxd_q;

  assign cnt_end = (cnt_q == LAST);
  assign tx_busy = (tx_st_q != TX_IDLE);

  always_comb begin
    tx_st_d  = tx_st_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    done_set = 1'b0;
    unique case (tx_st_q)
      TX_IDLE: begin
        if (txd_wr) begin
          tx_st_d = TX_START;
          sh_d    = Write_data[7:0];
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      TX_START: begin
        if (cnt_end) begin
          tx_st_d = TX_DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      TX_DATA: begin
        if (cnt_end) begin
          cnt_d = '0;
          sh_d  = {1'b0, sh_q[7:1]};
          if (bit_q == 3'd7) tx_st_d = TX_STOP;
          else bit_d = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      TX_STOP: begin
        if (cnt_end) begin
          tx_st_d  = TX_IDLE;
          cnt_d    = '0;
          done_set = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: tx_st_d = TX_IDLE;
    endcase
  end

  // Line level follows the next state so it changes on the same edge
  always_comb begin
    tx_d = 1'b1;
    if (tx_st_d == TX_START) tx_d = 1'b0;
    else if (tx_st_d == TX_DATA) tx_d = sh_d[0];
  end

  assign tx_done_d = done_set |
    (tx_done_q & ~(con_wr & Write_data[CON_TX_DONE]));
  assign irq_en_d = con_wr ? Write_data[CON_IRQ_EN] : irq_en_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_st_q   <= TX_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      tx_q      <= 1'b1;
      tx_done_q <= 1'b0;
      irq_en_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      tx_st_q   <= tx_st_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      tx_q      <= tx_d;
      tx_done_q <= tx_done_d;
      irq_en_q  <= irq_en_d;
      irq_q     <= irq_en_q & (tx_done_q | rx_valid_q);
    end
  end

`ifdef UART_MMIO_RX_EN
  logic       rx_done;
  logic [7:0] rx_byte;
  logic       rx_valid_d, rx_ovr_d;
  logic [7:0] rxd_d;

  uart_rx_core #(
    .BAUD_DIV(BAUD_DIV)
  ) u_rx (
    .clk   (clk),
    .reset (reset),
    .rx_i  (uart_rx),
    .byte_o(rx_byte),
    .done_o(rx_done)
  );

  assign rx_valid_d = rx_done | (rx_valid_q & ~rxd_rd);
  assign rx_ovr_d   = (rx_done & rx_valid_q) |
    (rx_ovr_q & ~(con_wr & Write_data[CON_RX_OVR]));
  assign rxd_d      = rx_done ? rx_byte : rxd_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rxd_q      <= '0;
    end else begin
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
      rxd_q      <= rxd_d;
    end
  end
`else
  logic unused_rx;
  assign unused_rx  = uart_rx ^ rxd_rd;
  assign rx_valid_q = 1'b0;
  assign rx_ovr_q   = 1'b0;
  assign rxd_q      = '0;
`endif

  logic unused_w;
  assign unused_w = ^{Write_data[31:8], Address[1:0]};

  logic [31:0] con_rd;
  always_comb begin
    con_rd              = '0;
    con_rd[CON_TX_BUSY] = tx_busy;
    con_rd[CON_TX_DONE] = tx_done_q;
    con_rd[CON_RX_VLD]  = rx_valid_q;
    con_rd[CON_RX_OVR]  = rx_ovr_q;
    con_rd[CON_IRQ_EN]  = irq_en_q;
  end

  always_comb begin
    Read_data = '0;
    if (MemRead) begin
      unique case (1'b1)
        sel_rxd: Read_data = {24'b0, rxd_q};
        sel_con: Read_data = con_rd;
        default: Read_data = '0;
      endcase
    end
  end

  assign uart_tx = tx_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio, BAUD_DIV = 4.
// TX frames are scored against a queue of expected bytes.
module tb_uart_mmio;

  localparam int BD = 4;
  localparam logic [31:0] A_TXD = 32'h4000_0018;
  localparam logic [31:0] A_RXD = 32'h4000_001C;
  localparam logic [31:0] A_CON = 32'h4000_0020;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Read_data;
  logic        uart_rx;
  logic        uart_tx;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b1;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];

  always #5 clk = ~clk;

  uart_mmio #(
    .BAUD_DIV(BD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .Address   (Address),
    .Write_data(Write_data),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Read_data (Read_data),
    .uart_rx   (uart_rx),
    .uart_tx   (uart_tx),
    .irq       (irq)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Address    = a;
    Write_data = d;
    MemWrite   = 1'b1;
    @(negedge clk);
    MemWrite   = 1'b0;
  endtask

  task automatic rd_chk(
    input string       tag,
    input logic [31:0] a,
    input logic [31:0] exp
  );
    logic [31:0] d;
    Address = a;
    MemRead = 1'b1;
    #1 d = Read_data;
    check(tag, d, exp);
    @(negedge clk);
    MemRead = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      repeat (BD) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (2 * BD) @(negedge clk);
  endtask

  initial begin : tx_mon
    forever begin
      logic [9:0] f;
      logic [7:0] b;
      @(negedge uart_tx);
      if (mon_en) begin
        check("tx_frame_expected", 32'(tx_exp.size() != 0), 1);
        b = (tx_exp.size() != 0) ? tx_exp.pop_front() : 8'h00;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10 * BD; i++) begin
          @(negedge clk);
          check($sformatf("tx_bit%0d", i / BD),
                32'(uart_tx), 32'(f[i / BD]));
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : main
    reset      = 1'b1;
    Address    = '0;
    Write_data = '0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    uart_rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(uart_tx), 1);
    check("rst_irq", 32'(irq), 0);
    rd_chk("rst_con", A_CON, 32'h0);
    rd_chk("rst_rxd", A_RXD, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    tx_exp.push_back(8'hA5);
    wr(A_TXD, 32'h0000_00A5);
    rd_chk("con_busy", A_CON, 32'h1);
    repeat (5) @(negedge clk);
    wr(A_TXD, 32'h0000_003C);
    rd_chk("con_busy2", A_CON, 32'h1);
    repeat (40) @(negedge clk);
    rd_chk("con_done", A_CON, 32'h2);
    wr(A_CON, 32'h2);
    rd_chk("con_w1c", A_CON, 32'h0);
    check("irq_off", 32'(irq), 0);

`ifdef UART_MMIO_RX_EN
    rx_exp.push_back(8'h5A);
    send(8'h5A, 1'b1);
    rd_chk("rx_vld", A_CON, 32'h4);
    rd_chk("rx_5a", A_RXD, 32'(rx_exp.pop_front()));
    rd_chk("rx_clr", A_CON, 32'h0);

    rx_exp.push_back(8'h22);
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    rd_chk("rx_ovr", A_CON, 32'hC);
    wr(A_CON, 32'h8);
    rd_chk("ovr_w1c", A_CON, 32'h4);
    rd_chk("rx_22", A_RXD, 32'(rx_exp.pop_front()));
    rd_chk("rx_clr2", A_CON, 32'h0);

    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (10) @(negedge clk);
    rd_chk("glitch", A_CON, 32'h0);
    send(8'h33, 1'b0);
    rd_chk("frm_con", A_CON, 32'h0);
    rd_chk("frm_rxd", A_RXD, 32'h22);
`else
    send(8'h5A, 1'b1);
    rd_chk("norx_rxd", A_RXD, 32'h0);
    rd_chk("norx_con", A_CON, 32'h0);
`endif

    wr(A_CON, 32'h10);
    rd_chk("irq_en", A_CON, 32'h10);
    tx_exp.push_back(8'h5E);
    wr(A_TXD, 32'h0000_005E);
    repeat (39) @(negedge clk);
    check("irq_pre", 32'(irq), 0);
    @(negedge clk);
    check("irq_lag", 32'(irq), 0);
    rd_chk("con_irq", A_CON, 32'h12);
    check("irq_on", 32'(irq), 1);

    mon_en = 1'b0;
    wr(A_TXD, 32'h0000_0000);
    repeat (10) @(negedge clk);
    check("mid_tx", 32'(uart_tx), 0);
    check("mid_irq", 32'(irq), 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_tx", 32'(uart_tx), 1);
    check("abort_irq", 32'(irq), 0);
    rd_chk("abort_con", A_CON, 32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("post_tx", 32'(uart_tx), 1);
    rd_chk("post_con", A_CON, 32'h0);
    check("tx_pending", 32'(tx_exp.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
